ped_request: RTL
================

# ped_request

Pedestrian push-button conditioner that sits directly upstream of the crossing controller FSM and drives its `start` input. It synchronises and debounces the raw button, latches one crossing request, and holds `start` high until the controller shows pedestrian green. It also drives the "WAIT" lamp and counts accepted requests.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles needed to accept a button level change (legal range 2..255).
- `CNT_W`, default 8: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clock`, input, 1: the single system clock, shared with the crossing controller.
- `reset`, input, 1: synchronous reset, active-high, sampled on the rising edge of `clock`.
- `button`, input, 1: raw, asynchronous, bouncing pedestrian button (1 = pressed).
- `lightseq`, input, 6: the controller's light output, fed back to this block.
- `start`, output, 1: registered crossing request to the controller.
- `wait_lamp`, output, 1: registered "WAIT" indicator.
- `presses`, output, 8: count of accepted requests.

## Operation
- **Synchroniser**: two flops, `button` → `s1` → `s2`. Only `s2` is used downstream.
- **Debounce**: holds `db_level` and counter `cnt`.
  - If `s2 == db_level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db_level <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Press event**: `press = db_level & ~db_prev`, where `db_prev` is `db_level` delayed one cycle. Only rising levels count; releases are ignored.
- **Green detect**: `ped_green = (lightseq == R_G)`, where R_G = 6'b100001.
- **Request FSM**, 3 states:
  - IDLE: `start=0`, `wait_lamp=0`. `press & ~ped_green` → PENDING and `presses <= presses+1`. `press & ped_green` is ignored; stay in IDLE.
  - PENDING: `start=1`, `wait_lamp=1`. `ped_green` → SERVING. A further `press` has no effect: no count, no state change.
  - SERVING: `start=0`, `wait_lamp=0`. Any `press` is ignored. `~ped_green` → IDLE.
- `start` and `wait_lamp` are decoded from the state register, so both are glitch-free registered signals.
- `presses` wraps from 255 to 0 with no saturation.
- Illegal state encoding → IDLE on the next edge.

## Timing
- Reset values on any rising edge with `reset=1`:
  - `s1 = s2 = db_level = db_prev = 0`, `cnt = 0`.
  - State = IDLE, so `start = 0` and `wait_lamp = 0`.
  - `presses = 0`.
- Reset mid-operation overrides everything, including a pending request, which is lost.
- Press latency: `button` rises before edge 0 and stays high.
  - `s2 = 1` after edge 1.
  - `db_level = 1` after edge DEBOUNCE_CYCLES+1.
  - `start`, `wait_lamp` and the `presses` increment all update after edge DEBOUNCE_CYCLES+2.
- Bounce rejection: any `s2` pulse back to `db_level` shorter than DEBOUNCE_CYCLES cycles restarts the count. `db_level` does not change.
- Release: `db_level` returns to 0 after the same latency. This has no FSM effect.
- Clear: `ped_green` is first seen high in PENDING at edge N; `start` is low after edge N.
  - The controller passes through its amber state for at least one cycle before R_G.
  - During that cycle `start` is still 1, which the controller has already consumed.
- Simultaneous events:
  - `press` and `ped_green` in the same cycle in IDLE → ignored.
  - `press` and `ped_green` in the same cycle in PENDING → SERVING.
  - `press` while `reset=1` → reset wins.

## Structure
- Shared package `crossing_pkg` holds:
  - The lightseq encodings G_R = 6'b001100, A_R = 6'b010100, R_G = 6'b100001 and RA_R = 6'b110100, shared with the controller.
  - The request-FSM state encoding: IDLE = 2'd0, PENDING = 2'd1, SERVING = 2'd2.
- Sub-module `button_debounce` contains the synchroniser plus the debounce counter.
  - Parameter: `DEBOUNCE_CYCLES`.
  - Ports: `clock`, `reset`, `raw`, `level`.
- The top level holds the edge detect, the FSM and the press counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- **Reset**: assert `reset` for 2 cycles with `button=1` → `start=0`, `wait_lamp=0`, `presses=0` throughout and on the first cycle after release.
- **Clean press**: `lightseq=G_R`, `button` high before edge 0 and held → `start` and `wait_lamp` become 1 after edge 6, `presses=1`. `start` holds until `lightseq=R_G`; `start` goes low after the first edge that sees R_G.
- **Bounce**: button pattern 1,1,0,1,1,0, then 0 → `start` stays 0 and `presses=0`. Then hold 1 for 6 cycles → `start=1` and `presses=1`.
- **Duplicate press**: a second clean press while PENDING → `presses` stays 1 and `start` stays 1.
- **Press during serving**: press while `lightseq=R_G` → ignored. When `lightseq` returns to G_R, the state is IDLE, `start=0` and `presses` is unchanged. A new press then gives `presses=2`.
- **Wrap and reset mid-request**:
  - Preload 255 accepted presses, then press once more → `presses=0`.
  - Assert `reset` while PENDING → `start=0` after that edge, and the request is not restored.

Source files
------------

// File: rtl/crossing_pkg.sv
//------------------------------------------------------------------------------
// Module : crossing_pkg
// Brief  : Light encodings and request-FSM states shared by the crossing blocks
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package crossing_pkg;

    localparam logic [5:0] G_R  = 6'b001100;
    localparam logic [5:0] A_R  = 6'b010100;
    localparam logic [5:0] R_G  = 6'b100001;
    localparam logic [5:0] RA_R = 6'b110100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2
    } req_state_t;

    function automatic logic is_ped_green(input logic [5:0] i_lightseq);
        return (i_lightseq == R_G);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ped_request_debounce.sv
//------------------------------------------------------------------------------
// Module : button_debounce
// Brief  : Two-flop synchroniser followed by a stable-level debounce counter
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1 <= raw;
            r_s2 <= r_s1;
            // Any sample agreeing with the held level restarts the stability run
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;

endmodule

`default_nettype wire

// File: rtl/ped_request.sv
//------------------------------------------------------------------------------
// Module : ped_request
// Brief  : Pedestrian button conditioner driving the crossing controller start
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module ped_request
    import crossing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       button,
    input  logic [5:0] lightseq,
    output logic       start,
    output logic       wait_lamp,
    output logic [7:0] presses
);

    logic       w_db_level;
    logic       w_press;
    logic       w_green;
    logic       w_count;
    req_state_t w_state_nxt;

    logic       r_db_prev;
    req_state_t r_state;
    logic       r_start;
    logic       r_wait;
    logic [7:0] r_presses;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clock (clock),
        .reset (reset),
        .raw   (button),
        .level (w_db_level)
    );

    assign w_press = w_db_level & ~r_db_prev;
    assign w_green = is_ped_green(lightseq);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_db_prev <= 1'b0;
            r_start   <= 1'b0;
            r_wait    <= 1'b0;
            r_presses <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_db_prev <= w_db_level;
            // Outputs follow the next state so they are clean flop outputs
            r_start   <= (w_state_nxt == PENDING);
            r_wait    <= (w_state_nxt == PENDING);
            if (w_count) begin
                r_presses <= r_presses + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        w_count     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press && !w_green) begin
                    w_state_nxt = PENDING;
                    w_count     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PENDING: begin
                w_state_nxt = w_green ? SERVING : PENDING;
            end
            SERVING: begin
                w_state_nxt = w_green ? SERVING : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign start     = r_start;
    assign wait_lamp = r_wait;
    assign presses   = r_presses;

endmodule

`default_nettype wire
